// File: rtl/ucode_pkg.sv
// Shared constants for the microcode sequencer: default control-word field
// positions, the idle word and the extension page names.
package ucode_pkg;

    localparam int unsigned DEF_RST_BIT  = 24;
    localparam int unsigned DEF_EXT_BIT  = 25;
    localparam int unsigned DEF_PAGE_LSB = 30;

    localparam logic [31:0] DEF_IDLE_WORD = 32'hFFFF_FFFF;

    // Extension pages; page 0 is the base opcode map.
    typedef enum logic [1:0] {
        PAGE_BASE = 2'd0,
        PAGE_EXT1 = 2'd1,
        PAGE_EXT2 = 2'd2,
        PAGE_EXT3 = 2'd3
    } page_e;

endpackage

// File: rtl/microcode_sequencer_if.sv
// Microcode ROM bus: the sequencer drives the address, the ROM returns data
// combinationally.
interface microcode_sequencer_if #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned CW_W   = 32
);
    logic [ADDR_W-1:0] rom_addr;
    logic [CW_W-1:0]   rom_data;

    modport master (output rom_addr, input  rom_data);
    modport slave  (input  rom_addr, output rom_data);
endinterface

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: micro-step counter, extension page register and
// ROM address / control word formation.
module microcode_sequencer
    import ucode_pkg::*;
#(
    parameter int unsigned OP_W     = 8,
    parameter int unsigned FLAG_W   = 4,
    parameter int unsigned STEP_W   = 3,
    parameter int unsigned PAGE_W   = 2,
    parameter int unsigned CW_W     = 32,
    parameter int unsigned RST_BIT  = DEF_RST_BIT,
    parameter int unsigned EXT_BIT  = DEF_EXT_BIT,
    parameter int unsigned PAGE_LSB = DEF_PAGE_LSB,
    parameter logic [CW_W-1:0] IDLE_WORD = CW_W'(DEF_IDLE_WORD)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [OP_W-1:0]     opcode,
    input  logic [FLAG_W-1:0]   flags,
    input  logic                hold,
    input  logic                abort_n,
    input  logic                ctrlen,
    microcode_sequencer_if.master rom,
    output logic [CW_W-1:0]     control_word,
    output logic [STEP_W-1:0]   step,
    output logic [PAGE_W-1:0]   page,
    output logic                instr_done,
    output logic                overrun
);

    localparam logic [STEP_W-1:0] STEP_LAST = '1;

    logic [STEP_W-1:0] step_d;
    logic [PAGE_W-1:0] page_d;
    logic              overrun_d;
    logic              instr_done_d;
    logic              end_n;
    logic              ext_n;
    logic [PAGE_W-1:0] page_field;

    // Sequencing bits come straight from the ROM, regardless of ctrlen.
    assign end_n      = rom.rom_data[RST_BIT];
    assign ext_n      = rom.rom_data[EXT_BIT];
    assign page_field = rom.rom_data[PAGE_LSB +: PAGE_W];

    // Mealy address and output paths.
    assign rom.rom_addr  = {page, opcode, step, flags};
    assign control_word  = ctrlen ? IDLE_WORD : rom.rom_data;

    // Next-state selection in priority order: abort, hold, end, advance.
    always_comb begin
        step_d       = step;
        page_d       = page;
        overrun_d    = overrun;
        instr_done_d = 1'b0;
        if (!abort_n) begin
            step_d       = '0;
            page_d       = PAGE_W'(PAGE_BASE);
            instr_done_d = 1'b1;
        end else if (hold) begin
            step_d = step;
        end else if (!end_n) begin
            step_d       = '0;
            page_d       = PAGE_W'(PAGE_BASE);
            instr_done_d = 1'b1;
        end else if (step == STEP_LAST) begin
            // Ran off the end without an end-of-instruction word.
            step_d    = '0;
            page_d    = PAGE_W'(PAGE_BASE);
            overrun_d = 1'b1;
        end else begin
            step_d = step + STEP_W'(1);
            if (!ext_n) begin
                page_d = page_field;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            step       <= '0;
            page       <= PAGE_W'(PAGE_BASE);
            overrun    <= 1'b0;
            instr_done <= 1'b0;
        end else begin
            step       <= step_d;
            page       <= page_d;
            overrun    <= overrun_d;
            instr_done <= instr_done_d;
        end
    end

endmodule

// File: doc/microcode_sequencer.md
# microcode_sequencer

Parametrised next-generation microcode sequencer for the CPU control path. It holds the micro-step counter and the extension-page register. It forms the microcode ROM address from page, opcode, step and flags, and returns the ROM word as the control word. Compared with the current control logic it adds:
- a multi-bit page instead of a single extension bit
- a configurable step depth
- a hold (wait-state) input
- a synchronous abort
- step-overrun detection

## Interface
Parameters:
- OP_W, 8, opcode width
- FLAG_W, 4, flags width (part of ROM address; alternate words selected by flags)
- STEP_W, 3, micro-step counter width
- PAGE_W, 2, extension page width (page 0 = base opcode map)
- CW_W, 32, control word width
- RST_BIT, 24, control-word bit; active-low "end of instruction, step reset"
- EXT_BIT, 25, control-word bit; active-low "load extension page"
- PAGE_LSB, 30, LSB of PAGE_W-wide page-select field in control word
- IDLE_WORD, all-ones, word driven when output disabled

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- opcode  in  OP_W  current instruction register value
- flags  in  FLAG_W  ALU flags
- hold  in  1  1 = freeze sequencer this cycle (wait state)
- abort_n  in  1  synchronous active-low abort: return to fetch
- ctrlen  in  1  active-low output enable; 1 forces IDLE_WORD
- rom_addr  out  PAGE_W+OP_W+STEP_W+FLAG_W  {page, opcode, step, flags}
- rom_data  in  CW_W  combinational microcode ROM data for rom_addr
- control_word  out  CW_W  ctrlen ? IDLE_WORD : rom_data
- step  out  STEP_W  current micro-step
- page  out  PAGE_W  current extension page
- instr_done  out  1  one-cycle pulse after an instruction-ending edge
- overrun  out  1  sticky: step counter wrapped without RST_BIT

## Operation
- State registers:
  - step
  - page
  - overrun
  - instr_done
- rom_addr and control_word are combinational from the state and inputs. There is no ROM inside the block.
- Sequencing bits (RST_BIT, EXT_BIT, page field) are always taken from rom_data, independent of ctrlen. Disabling the output never stalls sequencing.
- Step 0 of page 0 is the fetch micro-op, defined by ROM contents. The block has no special fetch logic.
- Rising edge of clk, in priority order:
  1. abort_n=0 → step=0, page=0, instr_done=1. This applies even when hold=1.
  2. hold=1 → step and page unchanged, instr_done=0.
  3. rom_data[RST_BIT]=0 → step=0, page=0, instr_done=1. Takes priority over EXT_BIT in the same word.
  4. Otherwise step=step+1, instr_done=0. If rom_data[EXT_BIT]=0, page=rom_data[PAGE_LSB +: PAGE_W]; else page is unchanged (sticky until instruction end).
  5. In case 4 with step=2^STEP_W−1, step wraps to 0, page=0 and overrun=1. instr_done stays 0.
- overrun clears only on rstn. abort_n does not clear it.
- Nested prefixes: an EXT word on a non-zero page overwrites page with the new field value.

## Timing
- Reset (rstn=0, asynchronous) sets step=0, page=0, overrun=0, instr_done=0. rom_addr is then {0, opcode, 0, flags}.
- Releasing rstn takes effect at the next rising edge. No extra delay cycle.
- Zero-latency Mealy path: an opcode or flags change updates rom_addr and control_word in the same cycle.
- One micro-step per unheld clock. An instruction of N micro-steps, including fetch, takes N clocks plus the number of hold cycles.
- instr_done is registered. It is high for exactly the cycle in which step=0 after an end, and for at most one cycle per end event.

## Structure
- Package ucode_pkg:
  - default field positions (RST_BIT, EXT_BIT, PAGE_LSB)
  - IDLE_WORD
  - page enumeration (PAGE_BASE=0, PAGE_EXT1=1, …)
- Single module, no sub-module in RTL.
- The bench uses a behavioural ucode_rom_model (a lookup on rom_addr) as the natural companion sub-module.

## Test plan
Bench uses default parameters and the ROM model.
1. Reset, then opcode=0x01, flags=0; ROM fetch word has RST_BIT=1. Expect control_word = fetch word, step 0→1 after one clk. ROM word at step 1 has RST_BIT=0; next clk gives step=0 and instr_done=1 for one cycle.
2. Flags alternate: opcode=0x17, step=1, flags=0x0 vs 0x4. Expect rom_addr flags field 0 then 4, and control_word switching to the alternate word in the same cycle with no clk.
3. Prefix: step-1 word has EXT_BIT=0 and page field=2. After clk, page=2 and rom_addr[MSBs]=2. page stays 2 through steps 2–3. The word with RST_BIT=0 returns page=0, step=0. A word with RST_BIT=0 and EXT_BIT=0 together leaves page=0.
4. hold=1 for 3 clks at step=2 → step stays 2, instr_done=0. abort_n=0 while hold=1 → step=0, page=0, instr_done=1.
5. Overrun: ROM never asserts RST_BIT. After 8 clks step wraps to 0, page=0, overrun=1. overrun stays 1 through abort_n and clears only on rstn=0.
6. ctrlen=1 mid-instruction → control_word=0xFFFFFFFF while step/page still advance per rom_data. Async rstn pulse mid-step clears all state without waiting for clk.
